// File: rtl/bcd_stopwatch_if.sv
// bcd_stopwatch_if: control/display bundle for the stopwatch core; lap/lap_active exist only with LAP_HOLD_EN.
interface bcd_stopwatch_if;
  logic        tick;
  logic        start_stop;
  logic        clear;
  logic [15:0] bcd;
  logic        running;
  logic        ovf;
`ifdef LAP_HOLD_EN
  logic        lap;
  logic        lap_active;
  modport master (output tick, start_stop, clear, lap, input bcd, running, ovf, lap_active);
  modport slave (input tick, start_stop, clear, lap, output bcd, running, ovf, lap_active);
`else
  modport master (output tick, start_stop, clear, input bcd, running, ovf);
  modport slave (input tick, start_stop, clear, output bcd, running, ovf);
`endif
endinterface

// File: rtl/bcd_stopwatch_core.sv
// bcd_stopwatch_core: 4-digit BCD stopwatch with IDLE/RUN/PAUSE control and tick prescaler.
// Optional lap freeze of the display is enabled by defining LAP_HOLD_EN.
module bcd_stopwatch_core #(
  parameter int DIV_TICKS = 10,
  parameter bit ROLLOVER  = 1
) (
  input logic clk,
  input logic rst,
  bcd_stopwatch_if.slave b
);
  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_e;
  state_e      state_q, state_d;
  logic [15:0] count_q, count_d;
  logic [7:0]  psc_q, psc_d;
  logic        ss_q, ovf_q, ovf_d, ss_edge, step, at_max, sat_hit;

  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (c) begin
        c = r[4*i +: 4] == 4'd9;
        r[4*i +: 4] = c ? 4'd0 : r[4*i +: 4] + 4'd1;
      end
    end
    return r;
  endfunction

  always_comb begin
    ss_edge = b.start_stop & ~ss_q;
    step    = state_q == RUN && b.tick && psc_q == 8'(DIV_TICKS - 1);
    at_max  = count_q == 16'h9999;
    sat_hit = step && at_max && !ROLLOVER;
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;

  // Saturation forces PAUSE even if a start_stop edge arrives in the same cycle.
  always_comb begin
    state_d = state_q;
    if (b.clear)      state_d = IDLE;
    else if (sat_hit) state_d = PAUSE;
    else if (ss_edge) state_d = state_q == RUN ? PAUSE : RUN;
  end

  always_comb begin
    psc_d   = (b.clear || state_q == IDLE) ? 8'd0 :
              (state_q == RUN && b.tick) ? (step ? 8'd0 : psc_q + 8'd1) : psc_q;
    count_d = b.clear ? 16'h0000 : (!step || sat_hit) ? count_q : bcd_inc(count_q);
    ovf_d   = !b.clear && step && at_max;
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      count_q <= '0;
      psc_q   <= '0;
      ss_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      psc_q   <= psc_d;
      ss_q    <= b.start_stop;
      ovf_q   <= ovf_d;
    end

`ifdef LAP_HOLD_EN
  logic        lap_q, frz_q, frz_d, lap_edge;
  logic [15:0] hold_q, hold_d;
  always_comb begin
    lap_edge = b.lap & ~lap_q;
    frz_d    = state_d == IDLE ? 1'b0 : (lap_edge && state_q != IDLE) ? ~frz_q : frz_q;
    hold_d   = (lap_edge && !frz_q) ? count_q : hold_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      lap_q  <= 1'b0;
      frz_q  <= 1'b0;
      hold_q <= '0;
    end else begin
      lap_q  <= b.lap;
      frz_q  <= frz_d;
      hold_q <= hold_d;
    end
  always_comb begin
    b.bcd        = frz_q ? hold_q : count_q;
    b.lap_active = frz_q;
  end
`else
  always_comb b.bcd = count_q;
`endif

  always_comb begin
    b.running = state_q == RUN;
    b.ovf     = ovf_q;
  end
endmodule
